spart_tx_engine: RTL and testbench

Transmit engine of the SPART, directly downstream of the SPART bus-interface/register block. It accepts a byte from the interface block's transmit buffer on `tx_begin`, holds it in a one-deep holding register, and serializes it onto `txd` as an 8N1 frame (start, 8 data LSB-first, stop). Bit timing comes from the 16-bit divisor register value supplied by the interface block. It reports holding-register availability back to the interface block as `tbr`.

---
 rtl/spart_pkg.sv | 6 +
 rtl/spart_baud_gen.sv | 26 ++
 rtl/spart_tx_engine.sv | 97 +++++++++
 tb/tb_spart_tx_engine.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared SPART definitions: transmit FSM states and frame geometry.
package spart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int FRAME_BITS     = 10;
endpackage

// File: rtl/spart_baud_gen.sv
// Baud tick generator: divisor is latched on load, then one tick every D+1 clocks.
module spart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] divisor,
  output logic        tick
);
  logic [15:0] div_q, cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      div_q <= divisor;
      cnt   <= divisor;
    end else if (cnt == 16'd0) begin
      cnt <= div_q;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

  assign tick = (cnt == 16'd0);
endmodule

// File: rtl/spart_tx_engine.sv
// SPART transmit engine: one-deep holding register feeding an 8N1 serializer.
module spart_tx_engine
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_begin,
  input  logic [7:0]  transmit_buffer,
  input  logic [15:0] divisor_buffer,
  output logic        txd,
  output logic        tbr,
  output logic        tx_busy,
  output logic        tx_overrun
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  tx_state_t     state, state_n;
  logic [7:0]    hold, shift, shift_n;
  logic          hold_valid;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic          tick, bit_end, xfer, accept, txd_n;

  spart_baud_gen u_baud (
    .clk     (clk),
    .rst     (rst),
    .load    (xfer),
    .divisor (divisor_buffer),
    .tick    (tick)
  );

  assign accept  = tx_begin && !hold_valid;
  assign bit_end = tick && (tick_cnt == TICK_LAST);
  assign tbr     = ~hold_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    xfer    = 1'b0;
    case (state)
      IDLE:  if (hold_valid) begin xfer = 1'b1; state_n = START; end
      START: if (bit_end) state_n = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_n = STOP;
      STOP:  if (bit_end) begin
               if (hold_valid) begin xfer = 1'b1; state_n = START; end
               else state_n = IDLE;
             end
      default: state_n = IDLE;
    endcase

    shift_n = shift;
    if (xfer) shift_n = hold;
    else if (state == DATA && bit_end) shift_n = {1'b0, shift[7:1]};

    // txd is registered, so it is computed from the state being entered.
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      shift      <= '0;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      txd        <= 1'b1;
      tx_busy    <= 1'b0;
      tx_overrun <= 1'b0;
    end else begin
      if (accept) begin
        hold       <= transmit_buffer;
        hold_valid <= 1'b1;
      end else if (xfer) begin
        hold_valid <= 1'b0;
      end
      tx_overrun <= tx_begin && hold_valid;
      shift      <= shift_n;
      txd        <= txd_n;
      tx_busy    <= (state_n != IDLE);
      if (xfer)                      tick_cnt <= '0;
      else if (state != IDLE && tick) tick_cnt <= tick_cnt + 1'b1;
      if (state == START)             bit_idx <= '0;
      else if (state == DATA && bit_end) bit_idx <= bit_idx + 3'd1;
    end
  end
endmodule

// File: tb/tb_spart_tx_engine.sv
// Bench for spart_tx_engine: stimulus queues expected frames, a line monitor checks them.
module tb_spart_tx_engine;
  import spart_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         d;
    int         lat;    // issue cycle, or -1 for no latency check
    int         gap;    // required idle clocks before start, or -1
    bit         abrt;   // frame is expected to be cut short by reset
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_begin;
  logic [7:0]  transmit_buffer;
  logic [15:0] divisor_buffer;
  logic        txd, tbr, tx_busy, tx_overrun;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   abort_req = 1'b0;
  bit   in_frame = 1'b0;
  exp_t q[$];

  spart_tx_engine dut (
    .clk             (clk),
    .rst             (rst),
    .tx_begin        (tx_begin),
    .transmit_buffer (transmit_buffer),
    .divisor_buffer  (divisor_buffer),
    .txd             (txd),
    .tbr             (tbr),
    .tx_busy         (tx_busy),
    .tx_overrun      (tx_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int d, input int gap,
                      input bit lat_chk, input bit abrt, input bit acc);
    exp_t e;
    @(negedge clk);
    tx_begin        = 1'b1;
    transmit_buffer = b;
    if (acc) begin
      e.data = b; e.d = d; e.gap = gap; e.abrt = abrt;
      e.lat  = lat_chk ? cyc : -1;
      q.push_back(e);
    end
    @(negedge clk);
    tx_begin = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while ((tx_busy !== 1'b0 || q.size() != 0 || in_frame) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", (n < budget) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // Line monitor: every cycle of every frame is compared against the queued byte.
  initial begin : monitor
    exp_t e;
    int   start_cyc, last_end, p, bad, n;
    bit   aborted;
    logic expb;
    last_end = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && txd === 1'b0) begin
        start_cyc = cyc;
        if (q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          n = 0;
          while (txd === 1'b0 && n < 100000) begin @(negedge clk); n++; end
        end else begin
          in_frame = 1'b1;
          e = q.pop_front();
          if (e.lat >= 0) chk($sformatf("latency_%02h", e.data), start_cyc - e.lat, 2);
          if (e.gap >= 0) chk($sformatf("gap_%02h", e.data), start_cyc - last_end - 1, e.gap);
          p = OVERSAMPLE_DEF * (e.d + 1);
          aborted = 1'b0;
          for (int b = 0; b < FRAME_BITS; b++) begin
            expb = (b == 0) ? 1'b0 : (b == FRAME_BITS - 1) ? 1'b1 : e.data[b-1];
            bad = 0;
            for (int c = 0; c < p; c++) begin
              if (!(b == 0 && c == 0)) begin
                @(negedge clk);
                if (abort_req) begin aborted = 1'b1; break; end
              end
              if (txd !== expb || tx_busy !== 1'b1) bad++;
            end
            if (aborted) break;
            chk($sformatf("frame_%02h_bit%0d_bad_cycles", e.data, b), bad, 0);
          end
          if (aborted) abort_req = 1'b0;
          chk($sformatf("frame_%02h_aborted", e.data), aborted, e.abrt);
          last_end = cyc;
          in_frame = 1'b0;
          if (!aborted && q.size() == 0) begin
            @(negedge clk);
            chk($sformatf("busy_after_%02h", e.data), tx_busy, 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog_timeout got %0d want 0", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; tx_begin = 1'b0; transmit_buffer = 8'h00; divisor_buffer = 16'd0;
    repeat (3) @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_tbr", tbr, 1);
    chk("reset_busy", tx_busy, 0);
    chk("reset_overrun", tx_overrun, 0);
    rst = 1'b0;

    // D=0, single frame, tbr handshake timing
    divisor_buffer = 16'd0;
    send(8'h55, 0, -1, 1, 0, 1);
    chk("tbr_low_after_accept", tbr, 0);
    @(negedge clk);
    chk("tbr_high_after_transfer", tbr, 1);
    wait_idle(2000);

    // D=3, 64-clock bits
    divisor_buffer = 16'd3;
    send(8'hA5, 3, -1, 1, 0, 1);
    wait_idle(3000);

    // back-to-back with zero gap
    divisor_buffer = 16'd0;
    send(8'h01, 0, -1, 1, 0, 1);
    repeat (30) @(negedge clk);
    send(8'h80, 0, 0, 0, 0, 1);
    chk("tbr_held", tbr, 0);
    wait_idle(2000);

    // overrun: 0xFF dropped, held 0xC3 still sent
    send(8'h3C, 0, -1, 1, 0, 1);
    repeat (5) @(negedge clk);
    send(8'hC3, 0, 0, 0, 0, 1);
    chk("tbr_full", tbr, 0);
    send(8'hFF, 0, -1, 0, 0, 0);
    chk("overrun_pulse", tx_overrun, 1);
    @(negedge clk);
    chk("overrun_one_cycle", tx_overrun, 0);
    wait_idle(2000);

    // divisor change mid-frame only affects the next frame
    divisor_buffer = 16'd1;
    send(8'hC6, 1, -1, 1, 0, 1);
    repeat (100) @(negedge clk);
    divisor_buffer = 16'd7;
    send(8'h39, 7, 0, 0, 0, 1);
    wait_idle(5000);

    // reset mid-DATA aborts, then a clean frame
    divisor_buffer = 16'd0;
    send(8'h5A, 0, -1, 1, 1, 1);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    abort_req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_txd", txd, 1);
    chk("rst_mid_tbr", tbr, 1);
    chk("rst_mid_busy", tx_busy, 0);
    repeat (3) @(negedge clk);
    send(8'h96, 0, -1, 1, 0, 1);
    wait_idle(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
